// File: rtl/fifo_ctrl.sv
// FIFO control and read path for an external bank of DEPTH 4-bit storage registers.
// Tracks pointers, occupancy and sticky error flags; drives one-hot load enables.
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_req,
    input  logic               rd_req,
    input  logic               err_clr,
    input  logic [DEPTH*4-1:0] store_q,
    output logic [DEPTH-1:0]   wr_en,
    output logic [3:0]         rd_data,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wrAcc, rdAcc;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Acceptance uses pre-edge full/empty, so a same-cycle pop never makes room for a push.
    assign wrAcc = wr_req & ~full & ~reset;
    assign rdAcc = rd_req & ~empty & ~reset;

    always_comb begin
        wr_en = '0;
        if (wrAcc) begin
            wr_en[wrPtr_q] = 1'b1;
        end
    end

    assign rd_data = store_q[{rdPtr_q, 2'b00} +: 4];

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~err_clr;
        underflow_d = underflow_q & ~err_clr;

        if (wrAcc) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        unique case ({wrAcc, rdAcc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event wins over a clear in the same cycle.
        if (wr_req & full) begin
            overflow_d = 1'b1;
        end
        if (rd_req & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: models the external storage registers, keeps a queue-based
// reference of the FIFO, and mixes directed scenarios with randomized traffic.
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               wr_req = 1'b0;
    logic               rd_req = 1'b0;
    logic               err_clr = 1'b0;
    logic [3:0]         regIn = 4'h0;
    logic [DEPTH*4-1:0] store_q;
    logic [DEPTH-1:0]   wr_en;
    logic [3:0]         rd_data;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic               overflow;
    logic               underflow;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .err_clr  (err_clr),
        .store_q  (store_q),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // External storage registers: each captures regIn when its enable is high.
    logic [3:0] storage [DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) storage[i] <= regIn;
        end
    end
    always_comb begin
        store_q = '0;
        for (int i = 0; i < DEPTH; i++) store_q[4*i +: 4] = storage[i];
    end

    // Reference model: FIFO contents as a queue plus the slot the next push lands in.
    logic [3:0] modelQ[$];
    int         wrSlot = 0;
    bit         modelOvf = 1'b0;
    bit         modelUnf = 1'b0;

    always @(posedge clk) begin
        int sz;
        bit wa, ra;
        sz = modelQ.size();
        if (reset) begin
            modelQ.delete();
            wrSlot   = 0;
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            wa = wr_req && (sz < DEPTH);
            ra = rd_req && (sz > 0);
            modelOvf = (wr_req && sz == DEPTH) || (modelOvf && !err_clr);
            modelUnf = (rd_req && sz == 0) || (modelUnf && !err_clr);
            if (ra) void'(modelQ.pop_front());
            if (wa) begin
                modelQ.push_back(regIn);
                wrSlot = (wrSlot + 1) % DEPTH;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, outputs are compared to the model mid-cycle.
    always @(negedge clk) begin
        logic [31:0] expWrEn;
        if (checking) begin
            expWrEn = (!reset && wr_req && modelQ.size() < DEPTH) ? (32'd1 << wrSlot) : 32'd0;
            checkOutput("wr_en", 32'(wr_en), expWrEn);
            checkOutput("count", 32'(count), 32'(modelQ.size()));
            checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
            checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
            checkOutput("overflow", 32'(overflow), 32'(modelOvf));
            checkOutput("underflow", 32'(underflow), 32'(modelUnf));
            if (modelQ.size() > 0) checkOutput("rd_data", 32'(rd_data), 32'(modelQ[0]));
        end
    end

    // Drives one cycle of inputs just after the edge and returns mid-cycle.
    task automatic applyStimulus(input bit rst, input bit w, input bit r, input bit c, input logic [3:0] d);
        @(posedge clk);
        #1;
        reset   = rst;
        wr_req  = w;
        rd_req  = r;
        err_clr = c;
        regIn   = d;
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        #1;
        checking = 1'b1;

        $display("[TB] reset with wr_req held high");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 4'h3);
            checkOutput("lit_rst_wr_en", 32'(wr_en), 32'h0);
        end
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_rst_count", 32'(count), 32'd0);
        checkOutput("lit_rst_empty", 32'(empty), 32'd1);
        checkOutput("lit_rst_full", 32'(full), 32'd0);

        $display("[TB] fill with 1..8 then drain");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0, 4'(i + 1));
            checkOutput("lit_fill_wr_en", 32'(wr_en), 32'd1 << i);
        end
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_fill_count", 32'(count), 32'd8);
        checkOutput("lit_fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 4'h0);
            checkOutput("lit_drain_rd_data", 32'(rd_data), 32'(i + 1));
        end
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_drain_empty", 32'(empty), 32'd1);

        $display("[TB] pointer wrap-around");
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 4'(i));
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 4'(4'hA + i));
            checkOutput("lit_wrap_wr_en", 32'(wr_en), 32'd1 << ((6 + i) % 8));
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 4'h0);
            checkOutput("lit_wrap_rd_data", 32'(rd_data), 32'(4'hA + i));
        end

        $display("[TB] full with push and pop");
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 4'(i + 1));
        applyStimulus(0, 1, 1, 0, 4'hF);
        checkOutput("lit_full_both_wr_en", 32'(wr_en), 32'h0);
        checkOutput("lit_full_both_rd_data", 32'(rd_data), 32'd1);
        applyStimulus(0, 0, 0, 1, 4'h0);
        checkOutput("lit_full_both_count", 32'(count), 32'd7);
        checkOutput("lit_full_both_ovf", 32'(overflow), 32'd1);
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_err_clr_ovf", 32'(overflow), 32'd0);

        $display("[TB] empty with push and pop");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 4'h0);
        applyStimulus(0, 1, 1, 0, 4'h5);
        checkOutput("lit_empty_both_wr_en", 32'(wr_en), 32'h08);
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_empty_both_count", 32'(count), 32'd1);
        checkOutput("lit_empty_both_unf", 32'(underflow), 32'd1);
        checkOutput("lit_empty_both_rd_data", 32'(rd_data), 32'h5);

        $display("[TB] steady push/pop at count 3, then reset");
        applyStimulus(0, 1, 0, 0, 4'h6);
        applyStimulus(0, 1, 0, 0, 4'h7);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, 0, 4'(8 + i));
            checkOutput("lit_steady_count", 32'(count), 32'd3);
        end
        applyStimulus(1, 1, 1, 0, 4'h9);
        applyStimulus(0, 1, 0, 0, 4'hC);
        checkOutput("lit_post_rst_count", 32'(count), 32'd0);
        checkOutput("lit_post_rst_wr_en", 32'(wr_en), 32'h01);
        applyStimulus(0, 0, 0, 0, 4'h0);
        checkOutput("lit_post_rst_rd_data", 32'(rd_data), 32'hC);

        $display("[TB] randomized traffic");
        for (int blk = 0; blk < 30; blk++) begin
            int wBias;
            int rBias;
            wBias = $urandom_range(20, 85);
            rBias = $urandom_range(20, 85);
            for (int i = 0; i < 80; i++) begin
                applyStimulus(($urandom_range(0, 199) == 0),
                              ($urandom_range(0, 99) < wBias),
                              ($urandom_range(0, 99) < rBias),
                              ($urandom_range(0, 15) == 0),
                              4'($urandom));
            end
        end

        applyStimulus(0, 0, 0, 0, 4'h0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
